// File: rtl/id_stage.sv
// Decode stage of the MyProc2 pipeline: register file, hazard detection,
// in-stage BEQ/JMP resolution and the registered ID/EX bundle.
module id_stage #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ins_in,
  input  logic             ins_valid,
  input  logic [WIDTH-3:0] pc_in,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic             is_stall,
  output logic             is_branch,
  output logic [WIDTH-3:0] branch_addr,
  output logic             ex_valid,
  output logic [2:0]       ex_alu_op,
  output logic [4:0]       ex_rd,
  output logic [WIDTH-1:0] ex_a,
  output logic [WIDTH-1:0] ex_b,
  output logic [WIDTH-1:0] ex_store_data,
  output logic             ex_mem_rd,
  output logic             ex_mem_wr,
  output logic             ex_reg_wr
);
  localparam int PCW = WIDTH - 2;

  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LD   = 6'h10;
  localparam logic [5:0] OP_ST   = 6'h11;
  localparam logic [5:0] OP_BEQ  = 6'h20;
  localparam logic [5:0] OP_JMP  = 6'h21;

  logic [WIDTH-1:0] regs [NREG];

  logic [5:0]       op;
  logic [4:0]       rd_f, src_a, src_b;
  logic             is_alu, is_addi, is_ld, is_st, is_beq, is_jmp;
  logic             use_a, use_b, writes_rd;
  logic [WIDTH-1:0] val_a, val_b, imm_ext;
  logic [PCW-1:0]   imm_pc, beq_tgt, jmp_tgt;
  logic [2:0]       alu_op;

  assign op      = ins_valid ? ins_in[31:26] : '0;
  assign rd_f    = ins_in[25:21];
  assign is_alu  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  assign is_addi = (op == OP_ADDI);
  assign is_ld   = (op == OP_LD);
  assign is_st   = (op == OP_ST);
  assign is_beq  = (op == OP_BEQ);
  assign is_jmp  = (op == OP_JMP);

  // BEQ takes its second operand from the rd field, so port B is muxed.
  assign src_a     = ins_in[20:16];
  assign src_b     = is_beq ? rd_f : ins_in[15:11];
  assign use_a     = is_alu || is_addi || is_ld || is_st || is_beq;
  assign use_b     = is_alu || is_st || is_beq;
  assign writes_rd = is_alu || is_addi || is_ld;

  assign val_a = (src_a == '0) ? '0 :
                 (wb_en && (wb_rd == src_a)) ? wb_data : regs[src_a];
  assign val_b = (src_b == '0) ? '0 :
                 (wb_en && (wb_rd == src_b)) ? wb_data : regs[src_b];

  assign imm_ext = {{(WIDTH-16){ins_in[15]}}, ins_in[15:0]};
  assign imm_pc  = PCW'(imm_ext);
  assign beq_tgt = pc_in + PCW'(4) + (imm_pc << 2);
  assign jmp_tgt = PCW'({ins_in[25:0], 2'b00});

  always_comb begin
    case (op)
      OP_SUB:  alu_op = 3'd1;
      OP_AND:  alu_op = 3'd2;
      OP_OR:   alu_op = 3'd3;
      default: alu_op = 3'd0;
    endcase
  end

  always_comb begin
    is_stall = 1'b0;
    if (ex_valid && ex_reg_wr && (ex_rd != '0) && (ex_mem_rd || is_beq))
      is_stall = (use_a && (ex_rd == src_a)) || (use_b && (ex_rd == src_b));
    is_branch   = !is_stall && (is_jmp || (is_beq && (val_a == val_b)));
    branch_addr = is_jmp ? jmp_tgt : beq_tgt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en && (wb_rd != '0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || is_stall) begin
      if (!rst_n) ex_valid <= 1'b0;
      else        ex_valid <= 1'b0;
      ex_alu_op     <= '0;
      ex_rd         <= '0;
      ex_a          <= '0;
      ex_b          <= '0;
      ex_store_data <= '0;
      ex_mem_rd     <= 1'b0;
      ex_mem_wr     <= 1'b0;
      ex_reg_wr     <= 1'b0;
    end else begin
      ex_valid      <= 1'b1;
      ex_alu_op     <= alu_op;
      ex_rd         <= writes_rd ? rd_f : '0;
      ex_a          <= val_a;
      ex_b          <= is_alu ? val_b : imm_ext;
      ex_store_data <= val_b;
      ex_mem_rd     <= is_ld;
      ex_mem_wr     <= is_st;
      ex_reg_wr     <= writes_rd;
    end
  end
endmodule

// File: tb/tb_id_stage.sv
// Directed and randomized checks of id_stage against a behavioural model of
// the decode rules, register file and hazard/branch behaviour.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ins_in;
  logic        ins_valid;
  logic [29:0] pc_in;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        is_stall, is_branch;
  logic [29:0] branch_addr;
  logic        ex_valid, ex_mem_rd, ex_mem_wr, ex_reg_wr;
  logic [2:0]  ex_alu_op;
  logic [4:0]  ex_rd;
  logic [31:0] ex_a, ex_b, ex_store_data;

  id_stage #(.WIDTH(32), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n), .ins_in(ins_in), .ins_valid(ins_valid),
    .pc_in(pc_in), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .is_stall(is_stall), .is_branch(is_branch), .branch_addr(branch_addr),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .ex_a(ex_a),
    .ex_b(ex_b), .ex_store_data(ex_store_data), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_reg_wr(ex_reg_wr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: architectural registers and what the ID/EX latch should hold.
  logic [31:0] mreg [32];
  logic        m_valid, m_reg_wr, m_mem_rd, m_mem_wr;
  logic [4:0]  m_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (wb_en && wb_rd == r) return wb_data;
    return mreg[r];
  endfunction

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] a,
                                      input logic [4:0] b, input logic [15:0] lo);
    return {op, a, b, lo};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    m_valid = 0; m_reg_wr = 0; m_mem_rd = 0; m_mem_wr = 0; m_rd = 0;
  endtask

  // One fetch cycle: drive inputs, check combinational controls, clock, check ID/EX.
  task automatic cycle(input logic [31:0] ins, input logic iv, input logic [29:0] pc,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       output logic stalled);
    logic [5:0]  op;
    logic [4:0]  rd, s1, s2, sb;
    logic [31:0] a, b, sx, st;
    logic        alu, regw, ld, sto, beq, jmp, hz, br;
    logic [29:0] tgt;
    logic [2:0]  aop;
    ins_in = ins; ins_valid = iv; pc_in = pc; wb_en = we; wb_rd = wr; wb_data = wd;
    #4;
    op = iv ? ins[31:26] : 6'h00;
    rd = ins[25:21]; s1 = ins[20:16]; s2 = ins[15:11];
    sx = {{16{ins[15]}}, ins[15:0]};
    alu = op inside {6'h01, 6'h02, 6'h03, 6'h04};
    ld = (op == 6'h10); sto = (op == 6'h11); beq = (op == 6'h20); jmp = (op == 6'h21);
    regw = alu || ld || op == 6'h08;
    aop = (op == 6'h02) ? 3'd1 : (op == 6'h03) ? 3'd2 : (op == 6'h04) ? 3'd3 : 3'd0;
    sb = beq ? rd : s2;
    a = mread(s1); b = mread(sb); st = mread(s2);
    hz = 0;
    if (m_valid && m_reg_wr && m_rd != 0 && (m_mem_rd || beq)) begin
      if ((alu || ld || sto || beq || op == 6'h08) && m_rd == s1) hz = 1;
      if ((alu || sto || beq) && m_rd == sb) hz = 1;
    end
    br = !hz && (jmp || (beq && a == b));
    tgt = jmp ? 30'({ins[25:0], 2'b00}) : 30'(pc + 30'd4 + 30'(sx * 4));
    chk("is_stall", 32'(is_stall), 32'(hz));
    chk("is_branch", 32'(is_branch), 32'(br));
    if (br) chk("branch_addr", 32'(branch_addr), 32'(tgt));
    @(posedge clk);
    if (we && wr != 0) mreg[wr] = wd;
    m_valid = !hz; m_reg_wr = !hz && regw; m_mem_rd = !hz && ld; m_mem_wr = !hz && sto;
    m_rd = (!hz && regw) ? rd : 5'd0;
    #1;
    chk("ex_valid", 32'(ex_valid), 32'(m_valid));
    chk("ex_reg_wr", 32'(ex_reg_wr), 32'(m_reg_wr));
    chk("ex_mem_rd", 32'(ex_mem_rd), 32'(m_mem_rd));
    chk("ex_mem_wr", 32'(ex_mem_wr), 32'(m_mem_wr));
    if (!hz && (regw || sto)) begin
      chk("ex_alu_op", 32'(ex_alu_op), 32'(aop));
      chk("ex_a", ex_a, a);
      chk("ex_b", ex_b, alu ? b : sx);
    end
    if (regw) chk("ex_rd", 32'(ex_rd), 32'(m_rd));
    if (!hz && sto) chk("ex_store_data", ex_store_data, st);
    stalled = hz;
  endtask

  // Presents an instruction until it issues; returns number of stall cycles.
  task automatic issue(input logic [31:0] ins, input logic [29:0] pc, output int nst);
    logic s;
    nst = 0;
    for (int k = 0; k < 3; k++) begin
      cycle(ins, 1'b1, pc, 1'b0, 5'd0, 32'd0, s);
      if (!s) break;
      nst++;
    end
    if (nst > 1) chk("stall_bound", 32'(nst), 32'd1);
  endtask

  logic s;
  int   nst;
  logic [5:0] ops [11] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h08,
                           6'h10, 6'h11, 6'h20, 6'h21, 6'h3F};

  initial begin
    rst_n = 0; ins_in = 0; ins_valid = 0; pc_in = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
    model_reset();
    #2;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_a", ex_a, 32'd0);
    chk("rst_is_stall", 32'(is_stall), 32'd0);
    @(posedge clk); #1; rst_n = 1;

    // Writeback r1=5, r2=7, then ADD r3,r1,r2.
    cycle(32'd0, 1'b0, 30'd0, 1'b1, 5'd1, 32'd5, s);
    cycle(32'd0, 1'b0, 30'd0, 1'b1, 5'd2, 32'd7, s);
    issue(enc(6'h01, 5'd3, 5'd1, {5'd2, 11'd0}), 30'h4, nst);
    chk("add_a_direct", ex_a, 32'd5);
    chk("add_b_direct", ex_b, 32'd7);

    // Load-use: LD r4,0(r1) then ADD r5,r4,r2 stalls exactly once.
    issue(enc(6'h10, 5'd4, 5'd1, 16'd0), 30'h8, nst);
    issue(enc(6'h01, 5'd5, 5'd4, {5'd2, 11'd0}), 30'hC, nst);
    chk("load_use_stalls", 32'(nst), 32'd1);
    chk("add_after_stall_rd", 32'(ex_rd), 32'd5);

    // BEQ r1,r1 +3 at 0x10 (taken), BEQ r1,r2 (not taken).
    issue(enc(6'h20, 5'd1, 5'd1, 16'd3), 30'h10, nst);
    issue(enc(6'h20, 5'd2, 5'd1, 16'd3), 30'h14, nst);
    // JMP 0x40 then its delay slot.
    cycle({6'h21, 26'h40}, 1'b1, 30'h18, 1'b0, 5'd0, 32'd0, s);
    issue(enc(6'h08, 5'd8, 5'd2, 16'd1), 30'h1C, nst);
    chk("delay_slot_b", ex_b, 32'd1);

    // Same-cycle writeback bypass on ADDI r7,r6,-1.
    cycle(enc(6'h08, 5'd7, 5'd6, 16'hFFFF), 1'b1, 30'h20, 1'b1, 5'd6, 32'hAB, s);
    chk("bypass_a", ex_a, 32'hAB);
    chk("bypass_b", ex_b, 32'hFFFF_FFFF);

    // Writes to r0 are discarded.
    cycle(32'd0, 1'b1, 30'h24, 1'b1, 5'd0, 32'h55, s);
    issue(enc(6'h01, 5'd9, 5'd0, {5'd0, 11'd0}), 30'h28, nst);
    chk("r0_reads_zero", ex_a, 32'd0);

    // Randomized traffic with random writebacks.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] ins;
      logic [4:0]  wr;
      ins = {ops[$urandom_range(0, 10)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 11'($urandom)};
      if ($urandom_range(0, 3) == 0) ins[15:0] = 16'($urandom);
      wr = 5'($urandom_range(0, 7));
      cycle(ins, $urandom_range(0, 7) != 0, 30'($urandom), 1'($urandom), wr, $urandom, s);
      if (s) cycle(ins, 1'b1, pc_in, 1'b0, 5'd0, 32'd0, s);
      if (s) chk("rand_stall_once", 32'(s), 32'd0);
    end

    // Asynchronous reset during a load-use stall.
    issue(enc(6'h10, 5'd4, 5'd1, 16'd0), 30'h30, nst);
    ins_in = enc(6'h01, 5'd5, 5'd4, 16'd0); ins_valid = 1; wb_en = 0;
    #4;
    chk("pre_reset_stall", 32'(is_stall), 32'd1);
    rst_n = 0;
    #1;
    chk("mid_rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("mid_rst_ex_reg_wr", 32'(ex_reg_wr), 32'd0);
    chk("mid_rst_ex_mem_rd", 32'(ex_mem_rd), 32'd0);
    chk("mid_rst_ex_rd", 32'(ex_rd), 32'd0);
    chk("mid_rst_ex_a", ex_a, 32'd0);
    chk("mid_rst_is_stall", 32'(is_stall), 32'd0);
    model_reset();
    @(posedge clk); #1; rst_n = 1;
    issue(enc(6'h01, 5'd3, 5'd1, {5'd2, 11'd0}), 30'h34, nst);
    chk("regs_cleared", ex_a, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the MyProc2 pipeline, directly downstream of instruction fetch; consumes the fetched instruction and its PC.
- Holds the 32-entry register file, resolves BEQ/JMP in-stage, and drives the stall and branch controls back to fetch.
- Detects load-use and branch-operand hazards.
- Produces the registered ID/EX pipeline bundle consumed by execute.

Parameters:
- WIDTH, 32, datapath width; PC width is WIDTH-2.
- NREG, 32, register count; r0 is hardwired to zero.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- ins_in  in  WIDTH  instruction from fetch.
- ins_valid  in  1  ins_in is valid; 0 decodes as NOP.
- pc_in  in  WIDTH-2  PC of ins_in.
- wb_en  in  1  writeback enable.
- wb_rd  in  5  writeback register.
- wb_data  in  WIDTH  writeback value.
- is_stall  out  1  combinational; fetch holds PC and instruction.
- is_branch  out  1  combinational; fetch loads branch_addr.
- branch_addr  out  WIDTH-2  branch/jump target.
- ex_valid  out  1  ID/EX bundle valid.
- ex_alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR.
- ex_rd  out  5  destination register.
- ex_a  out  WIDTH  rs1 value.
- ex_b  out  WIDTH  rs2 value, or sign-extended imm16 when the instruction is immediate-form.
- ex_store_data  out  WIDTH  rs2 value for ST.
- ex_mem_rd  out  1  load.
- ex_mem_wr  out  1  store.
- ex_reg_wr  out  1  writes ex_rd.

Behaviour:
- Instruction fields: op = [31:26], rd = [25:21], rs1 = [20:16], rs2 = [15:11], imm16 = [15:0], imm26 = [25:0].
- Opcodes:
  - 0x00 NOP.
  - 0x01 ADD, 0x02 SUB, 0x03 AND, 0x04 OR: rd = rs1 op rs2.
  - 0x08 ADDI: rd = rs1 + sext(imm16).
  - 0x10 LD: rd = mem[rs1 + sext(imm16)].
  - 0x11 ST: mem[rs1 + sext(imm16)] = rs2. The rd field is ignored.
  - 0x20 BEQ: compares rs1 (field [20:16]) with rs2 (field [25:21]).
  - 0x21 JMP: unconditional jump.
  - Any other opcode decodes as NOP.
- Register file:
  - Written on posedge when wb_en=1 and wb_rd!=0.
  - Reads are combinational with write-through bypass: when wb_en=1, wb_rd==src and src!=0, wb_data is returned.
  - r0 always reads 0.
- Hazard (is_stall=1) when ex_valid=1, ex_reg_wr=1, ex_rd!=0, and ex_rd matches a source register actually used by the current valid instruction, AND either:
  - ex_mem_rd=1 (load-use), or
  - the current instruction is BEQ.
- Stall response:
  - ID/EX loads a bubble: ex_valid=0 and all control bits 0.
  - ins_in/pc_in are held stable by fetch.
  - The stall lasts exactly one cycle per hazard, because the bubble clears the match.
- Branches:
  - BEQ taken when the operands are equal and there is no stall. is_branch=1, branch_addr = pc_in + 4 + (sext(imm16) << 2), truncated to WIDTH-2 bits.
  - JMP: is_branch=1, branch_addr = imm26 << 2, zero-extended/truncated to WIDTH-2 bits.
  - is_stall has priority: is_branch=0 while is_stall=1.
- Branch delay slot: exactly one. The instruction fetched alongside a taken branch enters ID next cycle and executes; there is no flush.
- BEQ, JMP and NOP enter ID/EX with ex_valid=1 and ex_reg_wr=ex_mem_rd=ex_mem_wr=0.
- Latency: the ID/EX bundle is registered one cycle after ins_in is presented, when there is no stall.
- Reset, asynchronous and at any time including mid-stall:
  - All ex_* outputs go to 0.
  - All registers are cleared to 0.
  - is_stall/is_branch evaluate with ex_valid=0, so they are 0 while ins_valid=0.
- Simultaneous writeback to a register being read: the bypass returns the new value in the same cycle.

Test Plan:
- Reset then wb r1=5, r2=7, then ADD r3,r1,r2 -> next cycle ex_valid=1, ex_alu_op=0, ex_a=5, ex_b=7, ex_rd=3, ex_reg_wr=1.
- LD r4,0(r1) followed by ADD r5,r4,r2 -> is_stall=1 for exactly one cycle and ex_valid=0 bubble, then ADD issues with ex_rd=5.
- BEQ r1,r1, imm=3 at pc_in=0x10 -> is_branch=1, branch_addr=0x20. With r1≠r2 -> is_branch=0.
- JMP imm26=0x40 -> is_branch=1, branch_addr=0x100. The next instruction (delay slot) issues normally.
- wb_en=1, wb_rd=6, wb_data=0xAB in the same cycle as ADDI r7,r6,-1 -> ex_a=0xAB, ex_b=0xFFFFFFFF.
- wb to r0 with 0x55, then read r0 -> 0. Assert rst_n low during a stall -> all ex_* = 0 immediately, is_stall=0.
